// File: rtl/cache_arbiter.sv
// Two-port (I/D) to single L2 line arbiter with a mandatory IDLE turnaround.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise D wins ties.
module cache_arbiter #(
  parameter int s_line = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [s_line-1:0] l2_wdata,
  input  logic [s_line-1:0] l2_rdata,
  input  logic              l2_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last_grant;
  logic       w_d_req;
  logic       w_tie_d;

  assign w_d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_tie_d = ~r_last_grant;
`else
  // last_grant is still tracked, but fixed priority ignores it
  assign w_tie_d = 1'b1 | r_last_grant;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_read && w_d_req)
          w_next = w_tie_d ? SERVE_D : SERVE_I;
        else if (i_read)
          w_next = SERVE_I;
        else if (w_d_req)
          w_next = SERVE_D;
      end
      SERVE_I,
      SERVE_D: begin
        if (l2_resp)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE)
        r_last_grant <= (w_next == SERVE_D);
    end
  end

  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (r_state)
      SERVE_I: begin
        l2_read    = 1'b1;
        l2_address = i_address;
        i_resp     = l2_resp;
      end
      SERVE_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
      end
      default: ;
    endcase
  end

endmodule
